regfile: RTL

General-purpose register file for the five-stage MIPS pipeline. The write port is driven by the writeback stage (`wb_wd`, `wb_wreg`, `wb_wdata` from the MEM/WB pipeline register). Two asynchronous read ports feed the decode stage. Register $0 is hardwired to zero. A same-cycle write is forwarded to either read port, so decode sees writeback results without an extra stall cycle.

---
 rtl/regfile_if.sv | 29 ++
 rtl/regfile.sv | 57 +++++
 2 files changed

// File: rtl/regfile_if.sv
// Register file access bundle: one write port and two independent read ports.
interface regfile_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
);
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              re1;
    logic [ADDR_W-1:0] raddr1;
    logic [DATA_W-1:0] rdata1;
    logic              re2;
    logic [ADDR_W-1:0] raddr2;
    logic [DATA_W-1:0] rdata2;

    // Pipeline side: writeback drives the write port, decode drives read addresses.
    modport master (
        output we, waddr, wdata,
        output re1, raddr1, re2, raddr2,
        input  rdata1, rdata2
    );

    // Register file side.
    modport slave (
        input  we, waddr, wdata,
        input  re1, raddr1, re2, raddr2,
        output rdata1, rdata2
    );
endinterface

// File: rtl/regfile.sv
// General-purpose register file: $0 hardwired to zero, synchronous write,
// two combinational read ports with same-cycle write-through bypass.
module regfile #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_REGS = 32
) (
    input logic      clk,
    input logic      rst,
    regfile_if.slave bus
);
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];

    // Next-state array: apply the writeback write unless it targets $0.
    always_comb begin
        regs_d = regs_q;
        if (bus.we && (bus.waddr != '0)) begin
            regs_d[bus.waddr] = bus.wdata;
        end
    end

    // Storage update; reset wins over any write presented in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read port 1: reset, $0 and disabled reads give zero; matching write bypasses.
    always_comb begin
        bus.rdata1 = '0;
        if (rst || (bus.raddr1 == '0) || !bus.re1) begin
            bus.rdata1 = '0;
        end else if (bus.we && (bus.waddr == bus.raddr1)) begin
            bus.rdata1 = bus.wdata;
        end else begin
            bus.rdata1 = regs_q[bus.raddr1];
        end
    end

    // Read port 2: same priority as port 1, fully independent.
    always_comb begin
        bus.rdata2 = '0;
        if (rst || (bus.raddr2 == '0) || !bus.re2) begin
            bus.rdata2 = '0;
        end else if (bus.we && (bus.waddr == bus.raddr2)) begin
            bus.rdata2 = bus.wdata;
        end else begin
            bus.rdata2 = regs_q[bus.raddr2];
        end
    end
endmodule
